// File: rtl/ptp_pkg.sv
// Shared types and constants for the PTP host bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ptp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRST = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } ptp_state_e;

    localparam logic PTP_OP_LOAD  = 1'b0;
    localparam logic PTP_OP_FETCH = 1'b1;

    localparam logic [3:0] PTP_LOAD_BYTES  = 4'd4;
    localparam logic [3:0] PTP_FETCH_BYTES = 4'd8;

    // Little-endian byte select out of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ptp_strobe_timer.sv
// Loadable 4-bit phase down-counter; phase_done_o is high while the count is zero.
// Latency: a load of V gives V+1 cycles until phase_done_o is seen (V = S-1 gives S cycles).
// Backpressure: none; the counter parks at zero until reloaded.
module ptp_strobe_timer (
    input  logic       clock,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       phase_done_o
);

    logic [3:0] count;

    // Count down from the loaded value and hold at zero.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            count <= 4'd0;
        end else if (load_i) begin
            count <= load_val_i;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign phase_done_o = (count == 4'd0);

endmodule

// File: rtl/ptp_host_bridge.sv
// Host end of the 8-bit PTP link: LOAD pushes a 32-bit word, FETCH pulls address+data words.
// Latency: LOAD 9S+1, FETCH 17S+1 cycles from acceptance to DONE; optional PTP_HOST_ADDR_CHECK_EN flags nonzero address bits [31:5].
// Backpressure: op_ready_o is high only in IDLE; commands offered while busy are ignored.
module ptp_host_bridge
    import ptp_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_i,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic        op_i,
    input  logic [31:0] wdata_i,
    output logic        rsp_valid_o,
    output logic [4:0]  rsp_addr_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [7:0]  ptp_byte_o,
    input  logic [7:0]  ptp_byte_i,
    output logic        ptp_ctrl_a_o,
    output logic        ptp_ctrl_b_o,
    output logic        ptp_reset_n_o
);

    localparam logic [3:0] PHASE_LOAD = 4'(STROBE_CYCLES - 1);

    ptp_state_e  state, state_nxt;
    logic        op, op_nxt;
    logic [31:0] wdata, wdata_nxt;
    logic [2:0]  k, k_nxt;
    logic [63:0] shift;
    logic        tmr_load;
    logic        phase_done;
    logic [3:0]  n_bytes;
    logic        accept;
    logic        rsp_fire;

    ptp_strobe_timer u_timer (
        .clock        (clock),
        .reset_i      (reset_i),
        .load_i       (tmr_load),
        .load_val_i   (PHASE_LOAD),
        .phase_done_o (phase_done)
    );

    assign accept   = op_valid_i & op_ready_o;
    assign n_bytes  = (op == PTP_OP_FETCH) ? PTP_FETCH_BYTES : PTP_LOAD_BYTES;
    assign rsp_fire = (state_nxt == ST_DONE) && (op == PTP_OP_FETCH);

    // Next-state logic: every phase change reloads the timer so each phase lasts S cycles.
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        wdata_nxt = wdata;
        k_nxt     = k;
        tmr_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_nxt    = op_i;
                    wdata_nxt = wdata_i;
                    k_nxt     = 3'd0;
                    state_nxt = ST_PRST;
                    tmr_load  = 1'b1;
                end
            end
            ST_PRST: begin
                if (phase_done) begin
                    state_nxt = ST_HIGH;
                    tmr_load  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_done) begin
                    state_nxt = ST_LOW;
                    tmr_load  = 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_done) begin
                    k_nxt = k + 3'd1;
                    if (({1'b0, k} + 4'd1) == n_bytes) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_HIGH;
                        tmr_load  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            state <= ST_IDLE;
            op    <= PTP_OP_LOAD;
            wdata <= 32'd0;
            k     <= 3'd0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            wdata <= wdata_nxt;
            k     <= k_nxt;
        end
    end

    // FETCH capture: the chip's byte is taken on the last cycle of each strobe-high phase.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            shift <= 64'd0;
        end else if ((state == ST_HIGH) && phase_done && (op == PTP_OP_FETCH)) begin
            shift[{k, 3'b000} +: 8] <= ptp_byte_i;
        end
    end

    // Link and handshake outputs are registered copies of what the next state implies.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            op_ready_o    <= 1'b0;
            ptp_reset_n_o <= 1'b0;
            ptp_ctrl_a_o  <= 1'b0;
            ptp_ctrl_b_o  <= 1'b0;
            ptp_byte_o    <= 8'd0;
        end else begin
            op_ready_o    <= (state_nxt == ST_IDLE);
            ptp_reset_n_o <= (state_nxt != ST_PRST);
            ptp_ctrl_a_o  <= (state_nxt == ST_HIGH) && (op_nxt == PTP_OP_LOAD);
            ptp_ctrl_b_o  <= (state_nxt == ST_HIGH) && (op_nxt == PTP_OP_FETCH);
            if ((op_nxt == PTP_OP_LOAD) && ((state_nxt == ST_HIGH) || (state_nxt == ST_LOW))) begin
                ptp_byte_o <= word_byte(wdata_nxt, k_nxt[1:0]);
            end else begin
                ptp_byte_o <= 8'd0;
            end
        end
    end

    // Response registers: pulse valid for the DONE cycle, hold address/data until the next FETCH.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            rsp_valid_o <= 1'b0;
            rsp_addr_o  <= 5'd0;
            rsp_data_o  <= 32'd0;
        end else begin
            rsp_valid_o <= rsp_fire;
            if (rsp_fire) begin
                rsp_addr_o <= shift[4:0];
                rsp_data_o <= shift[63:32];
            end
        end
    end

`ifdef PTP_HOST_ADDR_CHECK_EN
    // Address-word sanity: the baby's RAM has 32 words, so bits [31:5] must be zero.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            rsp_err_o <= 1'b0;
        end else if (rsp_fire) begin
            rsp_err_o <= |shift[31:5];
        end
    end
`else
    assign rsp_err_o = 1'b0;
    wire unused_addr_hi = |shift[31:5];
`endif

endmodule
